// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Holds the operation-mode encoding and the width helper for the shift counter.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_CLR  = 3'd6
  } usr_mode_e;

  // Bits needed to count from 0 up to and including width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One-bit storage cell with a per-instance reset value and complementary outputs.
// Ports: clk, rst_n (async, active-low), rst_val_i (value taken in reset),
//        d_i (next value, sampled on rising clk), q_o / nq_o (stored bit and its complement).
module usr_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o,
  output logic nq_o
);

  logic q_q;

  // Storage flop; the parent always supplies the next value, so no enable here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= rst_val_i;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o  = q_q;
  assign nq_o = ~q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, load, shift, rotate and clear, with a
// saturating shift counter and a one-cycle done pulse when a full word has moved.
// Ports: clk, rst_n (async, active-low), en (0 = hold all state), mode (operation),
//        sin (serial in), d (parallel load data), q / nq (contents and complement),
//        sout (last bit shifted/rotated out), cnt (shifts since LOAD/CLR), done.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [2:0]                      mode,
  input  logic                            sin,
  input  logic [WIDTH-1:0]                d,
  output logic [WIDTH-1:0]                q,
  output logic [WIDTH-1:0]                nq,
  output logic                            sout,
  output logic [cnt_width(WIDTH)-1:0]     cnt,
  output logic                            done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;

  // Next-state selection for the word, serial out and counter.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (en) begin
      case (usr_mode_e'(mode))
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
          shift  = 1'b1;
        end
        MODE_SHR: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          shift  = 1'b1;
        end
        MODE_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
          shift  = 1'b1;
        end
        MODE_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          shift  = 1'b1;
        end
        MODE_CLR: begin
          q_d    = '0;
          sout_d = 1'b0;
          cnt_d  = '0;
        end
        default: begin
        end
      endcase
    end
    // Counter saturates at WIDTH; done only on the WIDTH-1 -> WIDTH transition.
    if (shift) begin
      if (cnt_q < CW'(WIDTH)) begin
        cnt_d = cnt_q + CW'(1);
      end
      done_d = (cnt_q == CW'(WIDTH - 1));
    end
  end

  // Word storage, one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .rst_val_i (RESET_VAL[i]),
      .d_i       (q_d[i]),
      .q_o       (q_q[i]),
      .nq_o      (nq[i])
    );
  end

  // Serial-out, counter and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): directed vector
// table, hand-written reset sequences and randomized traffic against a reference model.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic       sin;
  logic [7:0] d;
  logic [7:0] q;
  logic [7:0] nq;
  logic       sout;
  logic [3:0] cnt;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int m_q, m_sout, m_cnt, m_done;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic       sin;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout;
    logic [3:0] cnt;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .sin   (sin),
    .d     (d),
    .q     (q),
    .nq    (nq),
    .sout  (sout),
    .cnt   (cnt),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %0h expected %0h", nm, n_vec, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int eq, input int es, input int ec, input int ed);
    n_vec++;
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".nq"},   32'(nq),   32'(255 - eq));
    chk({tag, ".sout"}, 32'(sout), 32'(es));
    chk({tag, ".cnt"},  32'(cnt),  32'(ec));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic step(input logic e, input logic [2:0] m, input logic s, input logic [7:0] dd);
    en   = e;
    mode = m;
    sin  = s;
    d    = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q = 0; m_sout = 0; m_cnt = 0; m_done = 0;
  endtask

  // Behavioural rules written with word arithmetic rather than bit slicing.
  task automatic model_step(input int e, input int m, input int s, input int dd);
    int out;
    bit is_shift;
    is_shift = 0;
    m_done   = 0;
    if (e != 0) begin
      case (m)
        1: begin m_q = dd; m_cnt = 0; end
        2: begin out = m_q / 128; m_q = (m_q * 2) % 256 + s;   m_sout = out; is_shift = 1; end
        3: begin out = m_q % 2;   m_q = m_q / 2 + s * 128;     m_sout = out; is_shift = 1; end
        4: begin out = m_q / 128; m_q = (m_q * 2) % 256 + out; m_sout = out; is_shift = 1; end
        5: begin out = m_q % 2;   m_q = m_q / 2 + out * 128;   m_sout = out; is_shift = 1; end
        6: begin m_q = 0; m_cnt = 0; m_sout = 0; end
        default: ;
      endcase
      if (is_shift) begin
        m_done = (m_cnt == 7) ? 1 : 0;
        if (m_cnt < 8) m_cnt = m_cnt + 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    mode  = 3'd0;
    sin   = 1'b0;
    d     = 8'h00;

    // Reset asserted between edges must act without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 0, 0, 0);
    en   = 1'b1;
    mode = 3'd1;
    d    = 8'hA5;
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("first_edge_load", 8'hA5, 0, 0, 0);

    // Directed table: {en, mode, sin, d, q, sout, cnt, done}.
    tbl.push_back('{1'b1, 3'd2, 1'b1, 8'h00, 8'h4B, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{1'b1, 3'd1, 1'b0, 8'h81, 8'h81, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'hC0, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'h60, 1'b0, 4'd2, 1'b0});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'h30, 1'b0, 4'd3, 1'b0});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'h18, 1'b0, 4'd4, 1'b0});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'h0C, 1'b0, 4'd5, 1'b0});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'h06, 1'b0, 4'd6, 1'b0});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'h03, 1'b0, 4'd7, 1'b0});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'h81, 1'b1, 4'd8, 1'b1});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 8'h00, 8'hC0, 1'b1, 4'd8, 1'b0});
    tbl.push_back('{1'b1, 3'd1, 1'b0, 8'hF0, 8'hF0, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 1'b1, 8'h00, 8'hF0, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 1'b1, 8'h00, 8'hF0, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 1'b1, 8'h00, 8'hF0, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{1'b1, 3'd7, 1'b1, 8'h55, 8'hF0, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{1'b1, 3'd4, 1'b0, 8'h00, 8'hE1, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{1'b1, 3'd1, 1'b0, 8'hFF, 8'hFF, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 1'b0, 8'h00, 8'hFE, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{1'b1, 3'd6, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].mode, tbl[i].sin, tbl[i].d);
      check_all("table", tbl[i].q, tbl[i].sout, tbl[i].cnt, tbl[i].done);
    end

    // Reset in the middle of a shift sequence discards the count.
    step(1'b1, 3'd1, 1'b0, 8'h3C);
    for (int i = 0; i < 5; i++) step(1'b1, 3'd3, 1'b0, 8'h00);
    check_all("shr5", 8'h01, 1, 5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_reset", 8'h00, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'd3, 1'b0, 8'h00);
      check_all("post_reset_shr", 8'h00, 0, i + 1, (i == 7) ? 1 : 0);
    end

    // Randomized traffic against the reference model, with occasional async resets.
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      int k, e, m, s, dd;
      if ($urandom_range(0, 99) < 2) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rand_reset", m_q, m_sout, m_cnt, m_done);
        #2;
        rst_n = 1'b1;
      end
      k  = int'($urandom_range(0, 15));
      e  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      s  = int'($urandom_range(0, 1));
      dd = int'($urandom_range(0, 255));
      case (k)
        0:       m = 1;
        1:       m = 6;
        2:       m = 0;
        3:       m = 7;
        default: m = 2 + (k % 4);
      endcase
      step(e[0], m[2:0], s[0], dd[7:0]);
      model_step(e, m, s, dd);
      check_all("random", m_q, m_sout, m_cnt, m_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: the next generation of the single-bit D flip-flop cell. It extends one stored bit to a WIDTH-bit word with hold, parallel load, logical shift, rotate and clear modes, and keeps the complementary-output convention (q and nq). A saturating shift counter with a done pulse lets serial-transfer logic (UART-style framing, serial/parallel converters in later lab blocks) know when a full word has been moved. It sits between datapath registers and serial I/O.

## Interface
- WIDTH, 8, word width in bits (≥2)
- RESET_VAL, 0, value of q after reset (WIDTH bits)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  operation enable; 0 = hold everything
- mode  input  3  operation select (see Operation)
- sin  input  1  serial input for logical shifts
- d  input  WIDTH  parallel load data
- q  output  WIDTH  register contents
- nq  output  WIDTH  bitwise complement of q
- sout  output  1  last bit shifted or rotated out
- cnt  output  $clog2(WIDTH+1)  shifts since last LOAD/CLR, saturating at WIDTH
- done  output  1  one-cycle pulse when cnt reaches WIDTH

## Operation
- Modes: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 CLR, 7 reserved and treated as HOLD.
- LOAD: q←d; cnt←0; sout unchanged.
- SHL: q←{q[WIDTH-2:0],sin}; sout←old q[WIDTH-1].
- SHR: q←{sin,q[WIDTH-1:1]}; sout←old q[0].
- ROL/ROR: same as SHL/SHR, with the vacated bit filled from the bit shifted out; sout gets that bit.
- CLR: q←0 (not RESET_VAL); cnt←0; sout←0.
- Each shift or rotate increments cnt when cnt<WIDTH. At cnt=WIDTH, cnt holds and the shift still executes.
- done←1 on the edge where cnt goes from WIDTH-1 to WIDTH; otherwise 0. It never asserts again until a LOAD/CLR and another WIDTH shifts.
- en=0: q, cnt and sout hold, and done←0, regardless of mode.
- nq is combinational ~q and always consistent with q, including during reset.

## Timing
- All state changes on the rising clk edge. Latency from inputs to q/sout/cnt/done is 1 cycle.
- rst_n low takes effect immediately, without a clock: q=RESET_VAL, nq=~RESET_VAL, sout=0, cnt=0, done=0.
- Reset release is synchronous in effect: the first operation executes on the first rising edge with rst_n high.
- Reset mid-sequence discards the count. The next shift yields cnt=1.
- Simultaneous events resolve by priority rst_n > en > mode.
- done is high for exactly one clock, the cycle after the WIDTH-th shift edge.

## Structure
- Package usr_pkg holds:
  - the mode encoding as named constants or an enum: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_CLR
  - the cnt-width function.
- Sub-module usr_bit_cell: a 1-bit storage cell with async active-low reset, reset value input, next-value input and q/nq outputs, instantiated WIDTH times via generate. The per-bit next-value mux lives in the parent.
- Counter, done and sout logic are in the parent.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=0.
- Assert rst_n=0 between edges → q=0x00, nq=0xFF, sout=0, cnt=0, done=0 with no clock edge; release → first edge executes the commanded mode.
- LOAD d=0xA5, then SHL with sin=1 → q=0xA5, nq=0x5A, cnt=0, then q=0x4B, sout=1, cnt=1.
- LOAD 0x81, then 8× ROR → q=0x81 after the 8th edge; done high for exactly one cycle after the 8th edge; 9th ROR gives q=0xC0, cnt stays 8, done=0.
- LOAD 0xF0, then en=0 with mode=SHL for 3 edges → q=0xF0, cnt=0, done=0 throughout; mode=7 with en=1 also holds.
- LOAD 0x3C, 5× SHR with sin=0, then rst_n pulse mid-cycle → q=0x00 and cnt=0 immediately; next SHR gives cnt=1 and no early done.
- LOAD 0xFF, SHL with sin=0, then CLR → q=0xFE, sout=1, then q=0x00, sout=0, cnt=0.
